fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream drain stage for the 8-bit synchronous FIFO. It pops one byte at a time through the FIFO read port and serializes it as a UART 8N1 frame (STOP_BITS configurable) on a single `tx` line. Bytes are sent LSB first at a fixed, parameterized baud divisor. The block holds a byte only while that byte is on the wire; the FIFO does all the buffering.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; legal range 2..65535
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `tx_en`  in  1  start-permission; when 0, no new frame is started
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_dout`  in  8  FIFO read data, registered in the FIFO, valid on the cycle after the read
- `fifo_rd_en`  out  1  FIFO read strobe, one cycle wide per byte
- `tx`  out  1  serial output; idle level is 1
- `busy`  out  1  1 in every state except IDLE
- `frame_done`  out  1  one-cycle pulse when a frame's last stop bit completes

## Operation
- Clock, reset and polarity are fixed: one clock `clk`; `rst` is asynchronous and active-high.
- States: IDLE, REQ, LOAD, START, DATA, STOP. The state, the baud counter (0..CLKS_PER_BIT-1), the bit index (0..7), the 8-bit shift register and `tx` are all registers.
- **IDLE**
  - If `tx_en`=1 and `fifo_empty`=0 at the clock edge, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `fifo_rd_en`=1. It is decoded from the state only: high exactly in REQ, and only one cycle.
  - Always go to LOAD.
- **LOAD**
  - `fifo_rd_en`=0.
  - At the edge ending LOAD: shift register <= `fifo_dout`, `tx`<=0, baud counter <= 0, go to START.
- **START**
  - Holds for CLKS_PER_BIT cycles.
  - Then `tx`<=shreg[0], bit index <= 0, go to DATA.
- **DATA**
  - Each bit holds for CLKS_PER_BIT cycles.
  - At the end of each bit: shift right, `tx`<=next bit, bit index +1.
  - After bit 7: `tx`<=1, go to STOP.
- **STOP**
  - Holds for STOP_BITS*CLKS_PER_BIT cycles.
  - Then go to IDLE and assert `frame_done` for one cycle.
- `fifo_rd_en` is never asserted unless `fifo_empty`=0 was sampled in IDLE on the preceding edge. The block never underflows the FIFO.
- `tx_en` is sampled only in IDLE. Dropping it mid-frame has no effect; the current frame completes.
- The baud counter wraps from CLKS_PER_BIT-1 to 0. Its width is the minimum needed for CLKS_PER_BIT-1.
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE, `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, counters=0.
  - A partially sent byte is discarded, not re-sent.
  - The byte already popped from the FIFO is lost.

## Timing
- Edge E0: IDLE sees `tx_en`=1 and `fifo_empty`=0.
- E1: the FIFO performs the read.
- E2: the byte is captured and the `tx` falling edge (start bit) occurs.
- Data bit i starts at E2+(i+1)*CLKS_PER_BIT.
- Stop starts at E2+9*CLKS_PER_BIT.
- IDLE is re-entered at E2+(9+STOP_BITS)*CLKS_PER_BIT, with `frame_done`=1 for that cycle.
- Back-to-back frames with the FIFO non-empty: frame period = (10+STOP_BITS-1)*CLKS_PER_BIT+3 cycles. That includes 3 extra idle-high cycles (IDLE, REQ, LOAD) between frames.
- `busy` rises at E0+ (the REQ cycle) and falls on the cycle `frame_done` is high.

## Test plan
- **Reset values:** assert `rst` mid-cycle with no clock running -> `tx`=1, `busy`=0, `fifo_rd_en`=0, `frame_done`=0 immediately.
- **Single byte:** CLKS_PER_BIT=4, STOP_BITS=1, one byte 0xA5 in the FIFO, `tx_en`=1.
  - `fifo_rd_en` is high for exactly 1 cycle.
  - `tx` sequence (4 cycles each) is 0, 1,0,1,0,0,1,0,1, then 1.
  - `frame_done` pulses 40 cycles after the start-bit edge.
- **Back-to-back:** 0x00, 0xFF, 0x3C queued.
  - Frame-to-frame start edges are 43 cycles apart.
  - Exactly 3 `fifo_rd_en` pulses occur.
  - No read occurs after `fifo_empty`=1.
- **Empty FIFO:** `fifo_empty`=1, `tx_en`=1 for 100 cycles -> `fifo_rd_en` never asserts, `tx` stays 1, `busy` stays 0.
- **Enable drop:** `tx_en` dropped during DATA of 0x81 -> the frame completes normally, and no further REQ occurs while `tx_en`=0 despite a non-empty FIFO.
- **Reset mid-frame:** `rst` pulsed in DATA bit 3 (STOP_BITS=2) -> `tx`=1 at once; after release with `tx_en`=1, the next FIFO byte is sent with full timing, including a 2-bit stop.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends each one as a UART 8N1 frame (1 or 2 stop bits), LSB first.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  localparam int CW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign fifo_rd_en = state == REQ;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = tx_en && !fifo_empty ? REQ : IDLE;
      REQ:     state_n = LOAD;
      LOAD:    state_n = START;
      START:   state_n = bit_end ? DATA : START;
      DATA:    state_n = bit_end && idx == 3'd7 ? STOP : DATA;
      STOP:    state_n = bit_end && idx == 3'(STOP_BITS - 1) ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // idx counts data bits in DATA and stop bits in STOP
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      tx <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= state == STOP && state_n == IDLE;
      cnt <= state inside {START, DATA, STOP} && !bit_end ? cnt + CW'(1) : '0;
      case (state)
        LOAD: begin
          shreg <= fifo_dout;
          tx <= 1'b0;
        end
        START: if (bit_end) begin
          tx <= shreg[0];
          idx <= '0;
        end
        DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          tx <= idx == 3'd7 ? 1'b1 : shreg[1];
          idx <= idx + 3'd1;
        end
        STOP: if (bit_end) idx <= idx == 3'(STOP_BITS - 1) ? 3'd0 : idx + 3'd1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of the UART drain stage with one and two stop bits, each fed by a small FIFO model.
module tb_fifo_uart_tx;
  logic clk = 0, run = 0, rst = 0, tx_en = 0, sel = 0;
  logic rd1, tx1, busy1, fd1, empty1, rd2, tx2, busy2, fd2, empty2;
  logic [7:0] dout1 = 0, dout2 = 0;
  logic [7:0] mem1 [16], mem2 [16];
  int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0, rdc1 = 0, rdc2 = 0, und = 0, cyc = 0;
  int n_chk = 0, n_pass = 0;
  logic rd_s, tx_s, busy_s, fd_s;

  always #5 if (run) clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty2), .fifo_dout(dout2),
    .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .frame_done(fd2));

  assign empty1 = wp1 == rp1;
  assign empty2 = wp2 == rp2;
  assign rd_s = sel ? rd2 : rd1;
  assign tx_s = sel ? tx2 : tx1;
  assign busy_s = sel ? busy2 : busy1;
  assign fd_s = sel ? fd2 : fd1;

  // FIFO models: registered read data, valid the cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd1) begin
      dout1 <= mem1[rp1 % 16];
      rp1 <= rp1 + 1;
      rdc1 <= rdc1 + 1;
      if (empty1) und <= und + 1;
    end
    if (rd2) begin
      dout2 <= mem2[rp2 % 16];
      rp2 <= rp2 + 1;
      rdc2 <= rdc2 + 1;
      if (empty2) und <= und + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic push(input logic u, input logic [7:0] b);
    if (u) begin mem2[wp2 % 16] = b; wp2++; end
    else begin mem1[wp1 % 16] = b; wp1++; end
  endtask

  // waits for the read strobe, then checks every cycle of the frame on tx
  task automatic frame(input logic [7:0] b, input int s, output int t_rd);
    int i = 0;
    t_rd = -1;
    do begin @(negedge clk); i++; end while (!rd_s && i < 200);
    if (!rd_s) begin chk("rd_timeout", 0, 1); return; end
    t_rd = cyc;
    @(negedge clk);
    chk("rd_width", int'(rd_s), 0);
    chk("load_tx_idle", int'(tx_s), 1);
    for (int k = 0; k < 9 + s; k++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("tx_%02h_bit%0d", b, k), int'(tx_s), k == 0 ? 0 : k <= 8 ? int'(b[k-1]) : 1);
        chk("busy_in_frame", int'(busy_s), 1);
        if (k == 8 + s && c == 3) chk("fd_early", int'(fd_s), 0);
      end
    @(negedge clk);
    chk("frame_done", int'(fd_s), 1);
    chk("busy_fall", int'(busy_s), 0);
    chk("tx_idle_after", int'(tx_s), 1);
  endtask

  initial begin
    int t0, t1, t2, r0, bad;
    #3 rst = 1;
    #1;
    chk("rst_tx", int'(tx1), 1);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_rd", int'(rd1), 0);
    chk("rst_fd", int'(fd1), 0);
    run = 1;
    repeat (3) @(negedge clk);
    rst = 0;

    push(0, 8'hA5);
    tx_en = 1;
    frame(8'hA5, 1, t0);
    chk("single_rd_count", rdc1, 1);

    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
    r0 = rdc1;
    frame(8'h00, 1, t0);
    frame(8'hFF, 1, t1);
    frame(8'h3C, 1, t2);
    chk("b2b_period1", t1 - t0, 43);
    chk("b2b_period2", t2 - t1, 43);
    repeat (60) @(negedge clk);
    chk("b2b_rd_count", rdc1 - r0, 3);
    chk("underflow", und, 0);

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd1 || !tx1 || busy1 || rd2 || !tx2 || busy2) bad++;
    end
    chk("empty_idle", bad, 0);

    push(0, 8'h81); push(0, 8'h55);
    r0 = rdc1;
    fork
      frame(8'h81, 1, t0);
      begin repeat (20) @(negedge clk); tx_en = 0; end
    join
    repeat (100) @(negedge clk);
    chk("en_drop_no_req", rdc1 - r0, 1);
    chk("en_drop_idle", int'(busy1), 0);
    tx_en = 1;
    frame(8'h55, 1, t0);

    sel = 1;
    push(1, 8'h6B); push(1, 8'hC4);
    begin
      int i = 0;
      do begin @(negedge clk); i++; end while (!rd2 && i < 200);
      chk("rst_mid_rd", int'(rd2), 1);
    end
    repeat (18) @(negedge clk);
    chk("pre_rst_busy", int'(busy2), 1);
    #1 rst = 1;
    #1;
    chk("mid_rst_tx", int'(tx2), 1);
    chk("mid_rst_busy", int'(busy2), 0);
    @(negedge clk);
    rst = 0;
    frame(8'hC4, 2, t0);
    chk("rst_rd_count", rdc2, 2);
    chk("underflow_end", und, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
